// File: rtl/serial_word_feeder_if.sv
// ---------------------------------------------------------------------------
// serial_word_feeder_if
//   Bundle between a word producer / serial detector and serial_word_feeder.
//
//   Producer side (master drives):
//     data_in   [WIDTH] word to serialise, MSB sent first
//     in_valid           data_in is valid
//     hold               downstream stall, pauses shifting while high
//   Feeder side (slave drives):
//     in_ready           feeder can accept a word
//     det_clear          one-cycle strobe clearing the detector remainder
//     bit_out            current serial bit
//     bit_valid          bit_out is consumed this cycle (detector enable)
//     first_bit          qualifies the word's MSB
//     last_bit           qualifies the word's LSB
//     word_done          one-cycle pulse after the last bit
// ---------------------------------------------------------------------------
interface serial_word_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic             in_ready;
    logic             hold;
    logic             det_clear;
    logic             bit_out;
    logic             bit_valid;
    logic             first_bit;
    logic             last_bit;
    logic             word_done;

    modport master (
        output data_in, in_valid, hold,
        input  in_ready, det_clear, bit_out, bit_valid,
               first_bit, last_bit, word_done
    );

    modport slave (
        input  data_in, in_valid, hold,
        output in_ready, det_clear, bit_out, bit_valid,
               first_bit, last_bit, word_done
    );
endinterface

// File: rtl/serial_word_feeder.sv
// ---------------------------------------------------------------------------
// serial_word_feeder
//   Upstream stage of the serial modulo-5 remainder detector. Accepts a
//   parallel word over valid/ready, strobes det_clear for one cycle, then
//   streams the word MSB-first (one bit per cycle with hold low) and pulses
//   word_done on the cycle after the last bit.
//
//   Parameters:
//     WIDTH   bits per word (minimum 2)
//   Ports:
//     clock   system clock, rising edge
//     reset   asynchronous, active-low reset
//     bus     serial_word_feeder_if.slave (handshake + detector-side signals)
// ---------------------------------------------------------------------------
module serial_word_feeder #(
    parameter int WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    serial_word_feeder_if.slave   bus
);

    localparam int              CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             det_clear_q;
    logic             word_done_q;

    logic             in_shift;
    logic             advance;

    assign in_shift = (state == SHIFT);
    assign advance  = in_shift && !bus.hold;

    // det_clear and word_done are registered so they coincide exactly with
    // the CLEAR and DONE states without decode glitches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            det_clear_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            det_clear_q <= 1'b0;
            word_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg       <= bus.data_in;
                        cnt         <= CNT_MAX;
                        det_clear_q <= 1'b1;
                        state       <= CLEAR;
                    end
                end
                CLEAR: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (!bus.hold) begin
                        if (cnt == '0) begin
                            word_done_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                            cnt   <= cnt - 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.det_clear = det_clear_q;
    assign bus.word_done = word_done_q;
    assign bus.bit_out   = in_shift && shreg[WIDTH-1];
    assign bus.bit_valid = advance;
    assign bus.first_bit = advance && (cnt == CNT_MAX);
    assign bus.last_bit  = advance && (cnt == '0);

endmodule

// File: tb/tb_serial_word_feeder.sv
// ---------------------------------------------------------------------------
// tb_serial_word_feeder
//   Self-checking bench for serial_word_feeder (WIDTH=8 main instance plus a
//   WIDTH=4 instance). A timeline reference model tracks progress through a
//   word and predicts every output each cycle; a small modulo-5 detector
//   folds the serial stream to check end-of-word remainders.
// ---------------------------------------------------------------------------
module tb_serial_word_feeder;

    localparam int W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    serial_word_feeder_if #(.WIDTH(8)) sif ();
    serial_word_feeder_if #(.WIDTH(4)) sif4 ();

    serial_word_feeder #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif)
    );

    serial_word_feeder #(.WIDTH(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (sif4)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (WIDTH=8) ----------------
    // p = progress since acceptance: 0 idle, 1 clear, 2..W+1 bits, W+2 done.
    int         p     = 0;
    logic [7:0] mword = '0;
    int         rem   = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) p <= 0;
        else if (p == 0) begin
            if (sif.in_valid) begin
                p     <= 1;
                mword <= sif.data_in;
            end
        end
        else if (p >= 2 && p <= W + 1 && sif.hold) p <= p;
        else if (p == W + 2) p <= 0;
        else p <= p + 1;
    end

    // downstream modulo-5 detector fed by the DUT's serial outputs
    always @(posedge clock or negedge reset) begin
        if (!reset) rem <= 0;
        else if (sif.det_clear) rem <= 0;
        else if (sif.bit_valid) rem <= (rem * 2 + int'(sif.bit_out)) % 5;
    end

    always begin
        @(negedge clock);
        #2;
        begin : bg
            bit inb;
            bit adv;
            int eb;
            inb = (p >= 2 && p <= W + 1);
            adv = inb && !sif.hold;
            eb  = inb ? int'(mword[W + 1 - p]) : 0;
            chk("in_ready",  sif.in_ready,  int'(p == 0));
            chk("det_clear", sif.det_clear, int'(p == 1));
            chk("bit_valid", sif.bit_valid, int'(adv));
            chk("bit_out",   sif.bit_out,   eb);
            chk("first_bit", sif.first_bit, int'(adv && p == 2));
            chk("last_bit",  sif.last_bit,  int'(adv && p == W + 1));
            chk("word_done", sif.word_done, int'(p == W + 2));
            if (p == W + 2) chk("remainder", rem, int'(mword) % 5);
        end
    end

    // ---------------- directed word runner ----------------
    task automatic run_word(input logic [7:0] d, input int hs, input int hl, input bit noise,
                            output int done_c, output int first_c, output int last_c,
                            output logic [7:0] rebuilt, output int nbits, output int r);
        @(negedge clock);
        sif.data_in  = d;
        sif.in_valid = 1'b1;
        sif.hold     = 1'b0;
        #1 chk("accept_ready", sif.in_ready, 1);
        done_c  = -1;
        first_c = -1;
        last_c  = -1;
        rebuilt = '0;
        nbits   = 0;
        r       = -1;
        for (int c = 1; c <= 40 && done_c < 0; c++) begin
            @(negedge clock);
            sif.hold     = (c >= hs && c < hs + hl);
            sif.in_valid = noise && c[0];
            sif.data_in  = noise ? 8'($urandom) : d;
            #1;
            if (sif.bit_valid) begin
                rebuilt = {rebuilt[6:0], sif.bit_out};
                nbits++;
            end
            if (sif.first_bit) first_c = c;
            if (sif.last_bit)  last_c  = c;
            if (sif.word_done) begin
                done_c = c;
                r      = rem;
            end
        end
        @(negedge clock);
        sif.in_valid = 1'b0;
        sif.hold     = 1'b0;
        #1 chk("ready_after_done", sif.in_ready, 1);
    endtask

    typedef struct {
        logic [7:0] data;
        int         hs;
        int         hl;
        bit         noise;
        int         exp_done;
        int         exp_first;
        int         exp_last;
        int         exp_rem;
    } vec_t;

    vec_t vecs[7];

    initial begin
        sif.data_in  = '0;
        sif.in_valid = 1'b0;
        sif.hold     = 1'b0;
        sif4.data_in  = '0;
        sif4.in_valid = 1'b0;
        sif4.hold     = 1'b0;

        // data, hold start, hold len, noise, done, first, last, remainder
        vecs[0] = '{8'hA5, 0,  0, 1'b0, 10, 2,  9, 0};
        vecs[1] = '{8'h07, 6,  3, 1'b0, 13, 2, 12, 2};
        vecs[2] = '{8'h01, 2,  2, 1'b0, 12, 4, 11, 1};
        vecs[3] = '{8'h3C, 1,  1, 1'b0, 10, 2,  9, 0};  // hold in CLEAR ignored
        vecs[4] = '{8'h2B, 10, 2, 1'b0, 10, 2,  9, 3};  // hold in DONE ignored
        vecs[5] = '{8'hC6, 0,  0, 1'b1, 10, 2,  9, 3};  // in_valid noise while busy
        vecs[6] = '{8'h9D, 3,  1, 1'b1, 11, 2, 10, 2};

        #1 reset = 1'b0;
        #2;
        chk("rst_in_ready",  sif.in_ready,  1);
        chk("rst_det_clear", sif.det_clear, 0);
        chk("rst_bit_valid", sif.bit_valid, 0);
        chk("rst_word_done", sif.word_done, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // ---- table-driven words ----
        foreach (vecs[i]) begin
            int dc, fc, lc, nb, r;
            logic [7:0] rb;
            run_word(vecs[i].data, vecs[i].hs, vecs[i].hl, vecs[i].noise, dc, fc, lc, rb, nb, r);
            chk($sformatf("v%0d_done_cycle", i),  dc, vecs[i].exp_done);
            chk($sformatf("v%0d_first_cycle", i), fc, vecs[i].exp_first);
            chk($sformatf("v%0d_last_cycle", i),  lc, vecs[i].exp_last);
            chk($sformatf("v%0d_word", i),        int'(rb), int'(vecs[i].data));
            chk($sformatf("v%0d_nbits", i),       nb, 8);
            chk($sformatf("v%0d_rem", i),         r, vecs[i].exp_rem);
        end

        // ---- back-to-back with in_valid held high ----
        begin
            int dcl[2];
            int dn[2];
            int rr[2];
            int ncl, ndn;
            ncl = 0;
            ndn = 0;
            dcl = '{-1, -1};
            dn  = '{-1, -1};
            rr  = '{-1, -1};
            @(negedge clock);
            sif.data_in  = 8'h0A;
            sif.in_valid = 1'b1;
            for (int c = 1; c <= 24; c++) begin
                @(negedge clock);
                sif.data_in  = (c >= 11) ? 8'hFF : 8'h0A;
                sif.in_valid = (c <= 11);
                #1;
                if (sif.det_clear) begin
                    if (ncl < 2) dcl[ncl] = c;
                    ncl++;
                end
                if (sif.word_done) begin
                    if (ndn < 2) begin
                        dn[ndn] = c;
                        rr[ndn] = rem;
                    end
                    ndn++;
                end
            end
            chk("b2b_clear0", dcl[0], 1);
            chk("b2b_clear1", dcl[1], 12);
            chk("b2b_done0",  dn[0], 10);
            chk("b2b_done1",  dn[1], 21);
            chk("b2b_ndone",  ndn, 2);
            chk("b2b_rem0",   rr[0], 0);
            chk("b2b_rem1",   rr[1], 0);
        end

        // ---- asynchronous reset mid-word ----
        begin
            int nd;
            nd = 0;
            @(negedge clock);
            sif.data_in  = 8'hC3;
            sif.in_valid = 1'b1;
            for (int c = 1; c <= 5; c++) begin
                @(negedge clock);
                sif.in_valid = 1'b0;
            end
            #1 reset = 1'b0;
            #1;
            chk("arst_in_ready",  sif.in_ready,  1);
            chk("arst_det_clear", sif.det_clear, 0);
            chk("arst_bit_out",   sif.bit_out,   0);
            chk("arst_bit_valid", sif.bit_valid, 0);
            chk("arst_first_bit", sif.first_bit, 0);
            chk("arst_last_bit",  sif.last_bit,  0);
            chk("arst_word_done", sif.word_done, 0);
            repeat (2) @(negedge clock);
            reset = 1'b1;
            for (int c = 0; c < 12; c++) begin
                @(negedge clock);
                #1;
                if (sif.word_done) nd++;
            end
            chk("arst_no_done", nd, 0);
            chk("arst_ready_after", sif.in_ready, 1);
        end

        // ---- WIDTH=4 instance ----
        begin
            int clr_c, fc, lc, dc, nb, r4, rdy7;
            logic [3:0] bits;
            clr_c = -1; fc = -1; lc = -1; dc = -1; nb = 0; r4 = 0; rdy7 = -1;
            bits = '0;
            @(negedge clock);
            sif4.data_in  = 4'hE;
            sif4.in_valid = 1'b1;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clock);
                sif4.in_valid = 1'b0;
                #1;
                if (sif4.det_clear) begin
                    clr_c = c;
                    r4    = 0;
                end
                if (sif4.bit_valid) begin
                    bits = {bits[2:0], sif4.bit_out};
                    r4   = (r4 * 2 + int'(sif4.bit_out)) % 5;
                    nb++;
                end
                if (sif4.first_bit) fc = c;
                if (sif4.last_bit)  lc = c;
                if (sif4.word_done) dc = c;
                if (c == 7) rdy7 = int'(sif4.in_ready);
            end
            chk("w4_clear",  clr_c, 1);
            chk("w4_bits",   int'(bits), 14);
            chk("w4_nbits",  nb, 4);
            chk("w4_first",  fc, 2);
            chk("w4_last",   lc, 5);
            chk("w4_done",   dc, 6);
            chk("w4_ready",  rdy7, 1);
            chk("w4_rem",    r4, 4);
        end

        // ---- randomized traffic, checked by the background model ----
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            sif.in_valid = 1'($urandom_range(0, 1));
            sif.data_in  = 8'($urandom);
            sif.hold     = ($urandom_range(0, 3) == 0);
        end
        @(negedge clock);
        sif.in_valid = 1'b0;
        sif.hold     = 1'b0;
        repeat (15) @(negedge clock);
        #3;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
